// File: rtl/seg14_bus_if.sv
// Scanned 14-segment display bus: one-hot digit select plus the segment
// pattern for the selected digit.
interface seg14_bus_if #(
  parameter int N_DIGITS = 12,
  parameter int SEG_W    = 14
);
  logic [N_DIGITS-1:0] sel;
  logic [SEG_W-1:0]    segm;

  modport master (output sel, output segm);
  modport slave  (input  sel, input  segm);
endinterface

// File: rtl/seg14_scan_decoder.sv
// Receive-side decoder for the 12-digit multiplexed 14-segment display bus:
// rebuilds character frames and flags scan-order and select-integrity faults.
module seg14_scan_decoder #(
  parameter int N_DIGITS = 12,
  parameter int SEG_W    = 14,
  parameter int CHAR_W   = 6,
  parameter int ERR_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  seg14_bus_if.slave                   bus,
  output logic [N_DIGITS*CHAR_W-1:0]   frame_chars,
  output logic                         frame_valid,
  output logic                         frame_unknown,
  output logic                         seq_err,
  output logic                         sel_err,
  output logic [ERR_W-1:0]             err_cnt
);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_DIGITS - 1);

  // Segment bit order a..f,g1,g2,h,i,j,k,l,m from bit 13 down to bit 0.
  function automatic logic [CHAR_W-1:0] decode_seg(input logic [SEG_W-1:0] p);
    case (p)
      14'h3F09: decode_seg = 6'h00;  14'h1808: decode_seg = 6'h01;
      14'h36C0: decode_seg = 6'h02;  14'h3C40: decode_seg = 6'h03;
      14'h19C0: decode_seg = 6'h04;  14'h2DC0: decode_seg = 6'h05;
      14'h2FC0: decode_seg = 6'h06;  14'h3800: decode_seg = 6'h07;
      14'h3FC0: decode_seg = 6'h08;  14'h3DC0: decode_seg = 6'h09;
      14'h3BC0: decode_seg = 6'h0A;  14'h3C52: decode_seg = 6'h0B;
      14'h2700: decode_seg = 6'h0C;  14'h3C12: decode_seg = 6'h0D;
      14'h2780: decode_seg = 6'h0E;  14'h2380: decode_seg = 6'h0F;
      14'h2F40: decode_seg = 6'h10;  14'h1BC0: decode_seg = 6'h11;
      14'h2412: decode_seg = 6'h12;  14'h1E00: decode_seg = 6'h13;
      14'h038C: decode_seg = 6'h14;  14'h0700: decode_seg = 6'h15;
      14'h1B28: decode_seg = 6'h16;  14'h1B24: decode_seg = 6'h17;
      14'h3F00: decode_seg = 6'h18;  14'h33C0: decode_seg = 6'h19;
      14'h3F04: decode_seg = 6'h1A;  14'h33C4: decode_seg = 6'h1B;
      14'h2012: decode_seg = 6'h1D;  14'h1F00: decode_seg = 6'h1E;
      14'h0309: decode_seg = 6'h1F;  14'h1B05: decode_seg = 6'h20;
      14'h002D: decode_seg = 6'h21;  14'h002A: decode_seg = 6'h22;
      14'h2409: decode_seg = 6'h23;  14'h3B24: decode_seg = 6'h24;
      14'h0000: decode_seg = 6'h25;
      default:  decode_seg = '1;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] sel_index(input logic [N_DIGITS-1:0] s);
    sel_index = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (s[i]) sel_index = IDX_W'(i);
  endfunction

  logic [N_DIGITS-1:0]              sel_p1;
  logic [SEG_W-1:0]                 segm_p1;
  logic [CHAR_W-1:0]                code_p1;
  logic                             unk_p1;
  logic                             multi_p1;
  logic                             one_p1;
  logic [IDX_W-1:0]                 idx_p1;

  logic [N_DIGITS-1:0][CHAR_W-1:0]  char_buf_p2;
  logic [IDX_W-1:0]                 exp_idx;
  logic                             unk_acc;
  logic                             done_p2;
  logic                             unk_p2;
  logic                             seq_p2;
  logic                             selerr_p2;

  // ---- stage 1: bus capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_p1  <= '0;
      segm_p1 <= '0;
    end else begin
      sel_p1  <= bus.sel;
      segm_p1 <= bus.segm;
    end
  end

  always_comb begin
    code_p1  = decode_seg(segm_p1);
    unk_p1   = (code_p1 == '1);
    multi_p1 = ((sel_p1 & (sel_p1 - 1'b1)) != '0);
    one_p1   = (sel_p1 != '0) && !multi_p1;
    idx_p1   = sel_index(sel_p1);
  end

  // ---- stage 2: frame assembly and scan-order tracking ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_buf_p2 <= '0;
      exp_idx     <= '0;
      unk_acc     <= 1'b0;
      done_p2     <= 1'b0;
      unk_p2      <= 1'b0;
      seq_p2      <= 1'b0;
      selerr_p2   <= 1'b0;
    end else begin
      done_p2   <= 1'b0;
      seq_p2    <= 1'b0;
      selerr_p2 <= 1'b0;
      if (multi_p1) begin
        selerr_p2 <= 1'b1;
        exp_idx   <= '0;
        unk_acc   <= 1'b0;
      end else if (one_p1) begin
        if (idx_p1 == exp_idx) begin
          char_buf_p2[idx_p1] <= code_p1;
          if (idx_p1 == LAST) begin
            done_p2 <= 1'b1;
            unk_p2  <= unk_acc | unk_p1;
            exp_idx <= '0;
            unk_acc <= 1'b0;
          end else begin
            exp_idx <= idx_p1 + 1'b1;
            unk_acc <= unk_acc | unk_p1;
          end
        end else begin
          seq_p2 <= 1'b1;
          // A stray digit 0 is taken as the start of a fresh frame.
          if (idx_p1 == '0) begin
            char_buf_p2[0] <= code_p1;
            exp_idx        <= IDX_W'(1);
            unk_acc        <= unk_p1;
          end else begin
            exp_idx <= '0;
            unk_acc <= 1'b0;
          end
        end
      end
    end
  end

  // ---- stage 3: published outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_chars   <= '0;
      frame_valid   <= 1'b0;
      frame_unknown <= 1'b0;
      seq_err       <= 1'b0;
      sel_err       <= 1'b0;
      err_cnt       <= '0;
    end else begin
      frame_valid <= done_p2;
      seq_err     <= seq_p2;
      sel_err     <= selerr_p2;
      // The buffer still holds the whole frame here even if digit 0 of the
      // next frame is being written on this same edge.
      if (done_p2) begin
        frame_chars   <= char_buf_p2;
        frame_unknown <= unk_p2;
      end
      if ((seq_p2 || selerr_p2) && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_seg14_scan_decoder.sv
// Directed bench for seg14_scan_decoder with hand-computed expected frames.
module tb_seg14_scan_decoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] frame_chars;
  logic        frame_valid, frame_unknown, seq_err, sel_err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_err    = 0;

  seg14_bus_if #(.N_DIGITS(12), .SEG_W(14)) bus ();

  seg14_scan_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .frame_chars   (frame_chars),
    .frame_valid   (frame_valid),
    .frame_unknown (frame_unknown),
    .seq_err       (seq_err),
    .sel_err       (sel_err),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  // P R O T O T Y P E V 1 space
  logic [13:0] pat_main [12] = '{14'h33C0, 14'h33C4, 14'h3F00, 14'h2012, 14'h3F00, 14'h2012,
                                 14'h002A, 14'h33C0, 14'h2780, 14'h0309, 14'h1808, 14'h0000};
  logic [5:0]  code_main [12] = '{6'h19, 6'h1B, 6'h18, 6'h1D, 6'h18, 6'h1D,
                                  6'h22, 6'h19, 6'h0E, 6'h1F, 6'h01, 6'h25};
  // Digit 2 = S/5 pattern, digit 3 = all segments lit (not a font entry)
  logic [13:0] pat_b [12] = '{14'h33C0, 14'h33C4, 14'h2DC0, 14'h3FFF, 14'h3F00, 14'h2012,
                              14'h002A, 14'h33C0, 14'h2780, 14'h0309, 14'h1808, 14'h0000};
  logic [5:0]  code_b [12] = '{6'h19, 6'h1B, 6'h05, 6'h3F, 6'h18, 6'h1D,
                               6'h22, 6'h19, 6'h0E, 6'h1F, 6'h01, 6'h25};
  logic [71:0] exp_main, exp_b;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [11:0] s, input logic [13:0] g);
    @(negedge clk);
    bus.sel  = s;
    bus.segm = g;
  endtask

  task automatic send(input bit use_b, input int lo, input int hi);
    logic [11:0] onehot;
    for (int k = lo; k <= hi; k++) begin
      onehot = 12'd1 << k;
      drive(onehot, use_b ? pat_b[k] : pat_main[k]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(12'h000, 14'h0000);
  endtask

  initial begin
    int pulses, last_pulse;
    logic [11:0] onehot;

    for (int k = 0; k < 12; k++) begin
      exp_main[k*6 +: 6] = code_main[k];
      exp_b[k*6 +: 6]    = code_b[k];
    end

    rst_n = 1'b0; bus.sel = '0; bus.segm = '0;
    idle(3);
    check("rst_chars",   frame_chars,         72'h0);
    check("rst_valid",   72'(frame_valid),    72'h0);
    check("rst_unknown", 72'(frame_unknown),  72'h0);
    check("rst_seq",     72'(seq_err),        72'h0);
    check("rst_sel",     72'(sel_err),        72'h0);
    check("rst_errcnt",  72'(err_cnt),        72'h0);
    rst_n = 1'b1;
    idle(2);

    // First frame: valid visible two edges after sel[11] is captured
    send(1'b0, 0, 11);
    idle(2);
    check("f1_valid_early", 72'(frame_valid), 72'h0);
    idle(1);
    check("f1_valid",   72'(frame_valid),   72'h1);
    check("f1_chars",   frame_chars,        exp_main);
    check("f1_unknown", 72'(frame_unknown), 72'h0);
    check("f1_errcnt",  72'(err_cnt),       72'h0);
    idle(1);
    check("f1_valid_drop", 72'(frame_valid), 72'h0);
    idle(2);

    // Three back-to-back frames
    pulses = 0; last_pulse = -1;
    for (int i = 0; i < 40; i++) begin
      onehot = 12'd1 << (i % 12);
      if (i < 36) drive(onehot, pat_main[i % 12]);
      else        drive(12'h000, 14'h0000);
      if (frame_valid === 1'b1) begin
        check("b2b_chars", frame_chars, exp_main);
        if (last_pulse >= 0) check("b2b_gap", 72'(i - last_pulse), 72'd12);
        last_pulse = i;
        pulses++;
      end
    end
    check("b2b_pulses", 72'(pulses), 72'd3);
    check("b2b_errcnt", 72'(err_cnt), 72'h0);

    // Skip from digit 4 to digit 6
    send(1'b0, 0, 4);
    send(1'b0, 6, 6);
    idle(3);
    check("skip_seq",    72'(seq_err),     72'h1);
    check("skip_sel",    72'(sel_err),     72'h0);
    check("skip_errcnt", 72'(err_cnt),     72'h1);
    check("skip_valid",  72'(frame_valid), 72'h0);
    idle(1);
    check("skip_seq_drop", 72'(seq_err), 72'h0);
    send(1'b0, 0, 11);
    idle(3);
    check("resume_valid", 72'(frame_valid), 72'h1);
    check("resume_chars", frame_chars,      exp_main);
    idle(2);

    // Multi-hot select in the middle of frame B
    send(1'b1, 0, 5);
    drive(12'b000000000011, 14'h3F00);
    idle(3);
    check("selerr_sel",    72'(sel_err),     72'h1);
    check("selerr_seq",    72'(seq_err),     72'h0);
    check("selerr_errcnt", 72'(err_cnt),     72'h2);
    check("selerr_chars",  frame_chars,      exp_main);
    check("selerr_valid",  72'(frame_valid), 72'h0);
    send(1'b1, 0, 11);
    idle(3);
    check("fb_valid",   72'(frame_valid),   72'h1);
    check("fb_chars",   frame_chars,        exp_b);
    check("fb_unknown", 72'(frame_unknown), 72'h1);
    check("fb_digit2",  72'(frame_chars[17:12]), 72'h05);
    idle(2);

    // Asynchronous reset between clock edges after digit 7
    send(1'b0, 0, 7);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_chars",   frame_chars,        72'h0);
    check("arst_valid",   72'(frame_valid),   72'h0);
    check("arst_unknown", 72'(frame_unknown), 72'h0);
    check("arst_seq",     72'(seq_err),       72'h0);
    check("arst_sel",     72'(sel_err),       72'h0);
    check("arst_errcnt",  72'(err_cnt),       72'h0);
    bus.sel = '0; bus.segm = '0;
    #1 rst_n = 1'b1;
    idle(2);
    send(1'b0, 0, 11);
    idle(3);
    check("post_valid",   72'(frame_valid),   72'h1);
    check("post_chars",   frame_chars,        exp_main);
    check("post_unknown", 72'(frame_unknown), 72'h0);
    check("post_errcnt",  72'(err_cnt),       72'h0);
    idle(2);

    // Repeated out-of-order digit 5: counter saturation
    for (int i = 0; i < 254; i++) drive(12'h020, 14'h2DC0);
    idle(3);
    check("sat_254", 72'(err_cnt), 72'hFE);
    for (int i = 0; i < 46; i++) drive(12'h020, 14'h2DC0);
    idle(3);
    check("sat_300", 72'(err_cnt), 72'hFF);
    check("sat_chars", frame_chars, exp_main);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
